// File: rtl/addr_xlate_sched.sv
// Schedules IF/MEM virtual-to-physical translation over one shared TLB port.
// kseg0/kseg1 (or everything under MAP_BYPASS) is fixed-mapped without touching the TLB.
module addr_xlate_sched #(
  parameter logic [2:0] K0_CACHED  = 3'b011,
  parameter bit         MAP_BYPASS = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [2:0]  cfg_k0,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_vaddr,
  output logic        if_resp_valid,
  output logic [31:0] if_paddr,
  output logic        if_uncached,
  output logic        if_miss,
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [31:0] mem_vaddr,
  output logic        mem_resp_valid,
  output logic [31:0] mem_paddr,
  output logic        mem_uncached,
  output logic        mem_miss,
  output logic        tlb_req_valid,
  input  logic        tlb_req_ready,
  output logic [31:0] tlb_vaddr,
  input  logic        tlb_resp_valid,
  input  logic        tlb_resp_hit,
  input  logic [31:0] tlb_resp_paddr,
  input  logic        tlb_resp_uncached
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TREQ  = 3'd1,
    S_TWAIT = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        owner;
  logic [31:0] vaddr_q;

  logic        grant_if, grant_mem, accept;
  logic [31:0] acc_vaddr;
  logic        is_kseg, is_fixed;
  logic [31:0] fix_paddr;
  logic        fix_unc;
  logic        ld_fixed, ld_tlb, ld_owner;
  logic [31:0] res_paddr;
  logic        res_unc, res_miss;

  // Requester id encoding: 0 = IF, 1 = MEM; last_grant resets to MEM so IF wins the first tie.
  always_comb begin
    grant_if      = if_req_valid & (~mem_req_valid | last_grant);
    grant_mem     = mem_req_valid & (~if_req_valid | ~last_grant);
    if_req_ready  = (state == S_IDLE) & ~flush & grant_if;
    mem_req_ready = (state == S_IDLE) & ~flush & grant_mem;
    accept        = if_req_ready | mem_req_ready;
    acc_vaddr     = mem_req_ready ? mem_vaddr : if_vaddr;
  end

  // Fixed mapping is evaluated on the accepted address so cfg_k0 is captured at acceptance.
  always_comb begin
    is_kseg   = (acc_vaddr[31:30] == 2'b10);
    is_fixed  = MAP_BYPASS | is_kseg;
    fix_paddr = is_kseg ? {3'b000, acc_vaddr[28:0]} : acc_vaddr;
    fix_unc   = is_kseg & (acc_vaddr[29] | (cfg_k0 != K0_CACHED));
    ld_fixed  = accept & is_fixed;
    ld_tlb    = (state == S_TWAIT) & tlb_resp_valid & ~flush;
    ld_owner  = ld_fixed ? mem_req_ready : owner;
    res_paddr = ld_fixed ? fix_paddr : (tlb_resp_hit ? tlb_resp_paddr : 32'd0);
    res_unc   = ld_fixed ? fix_unc : (tlb_resp_hit & tlb_resp_uncached);
    res_miss  = ~ld_fixed & ~tlb_resp_hit;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = is_fixed ? S_RESP : S_TREQ;
      S_TREQ: begin
        if (flush)              state_nxt = tlb_req_ready ? S_DRAIN : S_IDLE;
        else if (tlb_req_ready) state_nxt = S_TWAIT;
      end
      S_TWAIT: begin
        if (flush)               state_nxt = tlb_resp_valid ? S_IDLE : S_DRAIN;
        else if (tlb_resp_valid) state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      S_DRAIN: if (tlb_resp_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tlb_req_valid  = (state == S_TREQ);
    tlb_vaddr      = vaddr_q;
    if_resp_valid  = (state == S_RESP) & ~flush & ~owner;
    mem_resp_valid = (state == S_RESP) & ~flush & owner;
  end

  // Per-requester result registers hold their value between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      vaddr_q      <= 32'd0;
      if_paddr     <= 32'd0;
      if_uncached  <= 1'b0;
      if_miss      <= 1'b0;
      mem_paddr    <= 32'd0;
      mem_uncached <= 1'b0;
      mem_miss     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        vaddr_q    <= acc_vaddr;
        owner      <= mem_req_ready;
        last_grant <= mem_req_ready;
      end
      if (ld_fixed | ld_tlb) begin
        if (ld_owner) begin
          mem_paddr    <= res_paddr;
          mem_uncached <= res_unc;
          mem_miss     <= res_miss;
        end else begin
          if_paddr     <= res_paddr;
          if_uncached  <= res_unc;
          if_miss      <= res_miss;
        end
      end
    end
  end

endmodule

// File: tb/tb_addr_xlate_sched.sv
// Directed bench for addr_xlate_sched: expected responses are queued when requests
// are driven and popped by a monitor when either requester sees resp_valid.
module tb_addr_xlate_sched;

  logic        clk, rst_n, flush;
  logic [2:0]  cfg_k0;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_uncached, if_miss;
  logic [31:0] if_vaddr, if_paddr;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid, mem_uncached, mem_miss;
  logic [31:0] mem_vaddr, mem_paddr;
  logic        tlb_req_valid, tlb_req_ready, tlb_resp_valid, tlb_resp_hit, tlb_resp_uncached;
  logic [31:0] tlb_vaddr, tlb_resp_paddr;

  logic        b_if_req_ready, b_if_resp_valid, b_if_uncached, b_if_miss;
  logic [31:0] b_if_paddr;
  logic        b_mem_req_ready, b_mem_resp_valid, b_mem_uncached, b_mem_miss;
  logic [31:0] b_mem_paddr;
  logic        b_tlb_req_valid;
  logic [31:0] b_tlb_vaddr;
  logic        b_tlb_seen;

  typedef struct packed {
    logic        who;
    logic [31:0] pa;
    logic        unc;
    logic        miss;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  addr_xlate_sched dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_k0(cfg_k0),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_vaddr(if_vaddr),
    .if_resp_valid(if_resp_valid), .if_paddr(if_paddr), .if_uncached(if_uncached), .if_miss(if_miss),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_vaddr(mem_vaddr),
    .mem_resp_valid(mem_resp_valid), .mem_paddr(mem_paddr), .mem_uncached(mem_uncached), .mem_miss(mem_miss),
    .tlb_req_valid(tlb_req_valid), .tlb_req_ready(tlb_req_ready), .tlb_vaddr(tlb_vaddr),
    .tlb_resp_valid(tlb_resp_valid), .tlb_resp_hit(tlb_resp_hit),
    .tlb_resp_paddr(tlb_resp_paddr), .tlb_resp_uncached(tlb_resp_uncached)
  );

  addr_xlate_sched #(.MAP_BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_k0(cfg_k0),
    .if_req_valid(if_req_valid), .if_req_ready(b_if_req_ready), .if_vaddr(if_vaddr),
    .if_resp_valid(b_if_resp_valid), .if_paddr(b_if_paddr), .if_uncached(b_if_uncached), .if_miss(b_if_miss),
    .mem_req_valid(mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_vaddr(mem_vaddr),
    .mem_resp_valid(b_mem_resp_valid), .mem_paddr(b_mem_paddr), .mem_uncached(b_mem_uncached), .mem_miss(b_mem_miss),
    .tlb_req_valid(b_tlb_req_valid), .tlb_req_ready(tlb_req_ready), .tlb_vaddr(b_tlb_vaddr),
    .tlb_resp_valid(tlb_resp_valid), .tlb_resp_hit(tlb_resp_hit),
    .tlb_resp_paddr(tlb_resp_paddr), .tlb_resp_uncached(tlb_resp_uncached)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor on the main instance; also records any bypass TLB activity.
  always @(negedge clk) begin
    if (b_tlb_req_valid) b_tlb_seen <= 1'b1;
    if (rst_n && (if_resp_valid || mem_resp_valid)) begin
      checkOutput("resp_exclusive", 32'(if_resp_valid & mem_resp_valid), 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", 32'({if_resp_valid, mem_resp_valid}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("resp_owner", 32'(mem_resp_valid), 32'(mon_e.who));
        checkOutput("resp_paddr", mem_resp_valid ? mem_paddr : if_paddr, mon_e.pa);
        checkOutput("resp_uncached", 32'(mem_resp_valid ? mem_uncached : if_uncached), 32'(mon_e.unc));
        checkOutput("resp_miss", 32'(mem_resp_valid ? mem_miss : if_miss), 32'(mon_e.miss));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the request valid until the main instance accepts it; returns just after the accept edge.
  task automatic applyStimulus(input bit who, input logic [31:0] va);
    bit done = 1'b0;
    if (who) begin mem_req_valid = 1'b1; mem_vaddr = va; end
    else     begin if_req_valid  = 1'b1; if_vaddr  = va; end
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      done = who ? mem_req_ready : if_req_ready;
      tick();
    end
    if (who) mem_req_valid = 1'b0;
    else     if_req_valid  = 1'b0;
    if (!done) checkOutput("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic expectFixed(input bit who, input logic [31:0] va, input logic [31:0] pa, input bit unc);
    sb.push_back('{who: who, pa: pa, unc: unc, miss: 1'b0});
    applyStimulus(who, va);
    checkOutput("fixed_latency", 32'(who ? mem_resp_valid : if_resp_valid), 32'd1);
    tick();
  endtask

  task automatic tlbTxn(input bit who, input logic [31:0] va, input int rdy_delay,
                        input bit hit, input logic [31:0] rpa, input bit runc);
    applyStimulus(who, va);
    for (int i = 0; i < rdy_delay; i++) begin
      checkOutput("tlb_req_wait", 32'(tlb_req_valid), 32'd1);
      checkOutput("tlb_vaddr_stable", tlb_vaddr, va);
      tick();
    end
    tlb_req_ready = 1'b1;
    #1;
    checkOutput("tlb_vaddr_hs", tlb_vaddr, va);
    tick();
    tlb_req_ready = 1'b0;
    checkOutput("tlb_req_drop", 32'(tlb_req_valid), 32'd0);
    tick();
    if (hit) sb.push_back('{who: who, pa: rpa, unc: runc, miss: 1'b0});
    else     sb.push_back('{who: who, pa: 32'd0, unc: 1'b0, miss: 1'b1});
    tlb_resp_valid = 1'b1; tlb_resp_hit = hit; tlb_resp_paddr = rpa; tlb_resp_uncached = runc;
    tick();
    tlb_resp_valid = 1'b0;
    checkOutput("tlb_resp_latency", 32'(who ? mem_resp_valid : if_resp_valid), 32'd1);
    tick();
  endtask

  task automatic checkResetOuts();
    checkOutput("rst_ctrl", 32'({if_req_ready, mem_req_ready, if_resp_valid, mem_resp_valid,
                                 if_uncached, if_miss, mem_uncached, mem_miss, tlb_req_valid}), 32'd0);
    checkOutput("rst_if_paddr", if_paddr, 32'd0);
    checkOutput("rst_mem_paddr", mem_paddr, 32'd0);
    checkOutput("rst_tlb_vaddr", tlb_vaddr, 32'd0);
    checkOutput("rst_bypass", 32'({b_if_req_ready, b_if_resp_valid, b_if_uncached, b_if_miss,
                                   b_mem_req_ready, b_mem_resp_valid, b_mem_uncached, b_mem_miss,
                                   b_tlb_req_valid, |b_if_paddr, |b_mem_paddr, |b_tlb_vaddr}), 32'd0);
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; cfg_k0 = 3'd3; b_tlb_seen = 1'b0;
    if_req_valid = 1'b0; if_vaddr = '0; mem_req_valid = 1'b0; mem_vaddr = '0;
    tlb_req_ready = 1'b0; tlb_resp_valid = 1'b0; tlb_resp_hit = 1'b0;
    tlb_resp_paddr = '0; tlb_resp_uncached = 1'b0;
    tick();
    checkResetOuts();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] fixed kseg0/kseg1 mapping");
    expectFixed(1'b0, 32'h9FC0_0010, 32'h1FC0_0010, 1'b0);
    expectFixed(1'b1, 32'hBFD0_1000, 32'h1FD0_1000, 1'b1);
    cfg_k0 = 3'd2;
    expectFixed(1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1);
    cfg_k0 = 3'd3;

    $display("[TB] TLB hit and miss");
    tlbTxn(1'b1, 32'h0040_0000, 2, 1'b1, 32'h0123_4000, 1'b0);
    tlbTxn(1'b1, 32'h0040_0000, 0, 1'b0, 32'hDEAD_0000, 1'b1);

    $display("[TB] round-robin arbitration");
    resetPulse();
    if_req_valid = 1'b1;  if_vaddr  = 32'h8000_1000;
    mem_req_valid = 1'b1; mem_vaddr = 32'hA000_2000;
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput("arb_if_ready", 32'(if_req_ready), 32'(k % 4 == 0));
      checkOutput("arb_mem_ready", 32'(mem_req_ready), 32'(k % 4 == 2));
      if (k % 4 == 0) sb.push_back('{who: 1'b0, pa: 32'h0000_1000, unc: 1'b0, miss: 1'b0});
      if (k % 4 == 2) sb.push_back('{who: 1'b1, pa: 32'h0000_2000, unc: 1'b1, miss: 1'b0});
      tick();
    end
    if_req_valid = 1'b0; mem_req_valid = 1'b0;
    tick();

    $display("[TB] flush while waiting for TLB");
    applyStimulus(1'b1, 32'h0000_1000);
    tlb_req_ready = 1'b1;
    tick();
    tlb_req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    tlb_resp_valid = 1'b1; tlb_resp_hit = 1'b1; tlb_resp_paddr = 32'h0777_0000;
    tick();
    tlb_resp_valid = 1'b0;
    checkOutput("twait_flush_quiet", 32'({if_resp_valid, mem_resp_valid}), 32'd0);
    expectFixed(1'b0, 32'h9FC0_0010, 32'h1FC0_0010, 1'b0);

    $display("[TB] flush in response cycle");
    applyStimulus(1'b0, 32'h8000_0040);
    flush = 1'b1;
    #1;
    checkOutput("resp_flush_sup", 32'(if_resp_valid), 32'd0);
    tick();
    flush = 1'b0;

    $display("[TB] flush on TLB handshake");
    applyStimulus(1'b1, 32'h0000_2000);
    tlb_req_ready = 1'b1; flush = 1'b1;
    tick();
    tlb_req_ready = 1'b0; flush = 1'b0;
    mem_req_valid = 1'b1; mem_vaddr = 32'hA000_3000;
    #1;
    checkOutput("drain_ready", 32'(mem_req_ready), 32'd0);
    checkOutput("drain_tlb_valid", 32'(tlb_req_valid), 32'd0);
    tick();
    #1;
    checkOutput("drain_hold", 32'(mem_req_ready), 32'd0);
    tlb_resp_valid = 1'b1; tlb_resp_hit = 1'b1; tlb_resp_paddr = 32'h0555_0000;
    tick();
    tlb_resp_valid = 1'b0;
    #1;
    checkOutput("post_drain_ready", 32'(mem_req_ready), 32'd1);
    sb.push_back('{who: 1'b1, pa: 32'h0000_3000, unc: 1'b1, miss: 1'b0});
    tick();
    mem_req_valid = 1'b0;
    checkOutput("post_drain_latency", 32'(mem_resp_valid), 32'd1);
    tick();

    $display("[TB] bypass instance and reset mid-TREQ");
    resetPulse();
    mem_req_valid = 1'b1; mem_vaddr = 32'h0040_0000;
    #1;
    checkOutput("byp_ready", 32'(b_mem_req_ready), 32'd1);
    tick();
    mem_req_valid = 1'b0;
    checkOutput("byp_resp_valid", 32'(b_mem_resp_valid), 32'd1);
    checkOutput("byp_paddr", b_mem_paddr, 32'h0040_0000);
    checkOutput("byp_flags", 32'({b_mem_uncached, b_mem_miss}), 32'd0);
    checkOutput("main_in_treq", 32'(tlb_req_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOuts();
    tick();
    rst_n = 1'b1;
    tlb_resp_valid = 1'b1; tlb_resp_hit = 1'b1; tlb_resp_paddr = 32'h0999_0000;
    tick();
    tlb_resp_valid = 1'b0;
    tick();
    checkOutput("post_rst_quiet", 32'({if_resp_valid, mem_resp_valid}), 32'd0);
    checkOutput("byp_tlb_unused", 32'(b_tlb_seen), 32'd0);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
